// File: rtl/dsp_systolic_dot_ctrl.sv
// Job controller for a systolic dot-product datapath: feeds operand chunks, tracks
// in-flight products and accumulates the chain results into one job result.
module dsp_systolic_dot_ctrl #(
    parameter int unsigned NUM            = 10,
    parameter int unsigned AX_WIDTH       = 27,
    parameter int unsigned AY_WIDTH       = 27,
    parameter int unsigned RESULT_A_WIDTH = 64,
    parameter int unsigned DP_LATENCY     = 3,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned ACC_WIDTH      = 72
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic                      abort,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM*AX_WIDTH-1:0]   in_ax,
    input  logic [NUM*AY_WIDTH-1:0]   in_ay,
    output logic [NUM*AX_WIDTH-1:0]   dp_ax,
    output logic [NUM*AY_WIDTH-1:0]   dp_ay,
    input  logic [RESULT_A_WIDTH-1:0] dp_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_result
);

    localparam int unsigned AXW = NUM * AX_WIDTH;
    localparam int unsigned AYW = NUM * AY_WIDTH;
    localparam int unsigned VW  = DP_LATENCY + 1;

    if (ACC_WIDTH < RESULT_A_WIDTH + LEN_WIDTH) begin : g_acc_width_check
        $error("ACC_WIDTH must be at least RESULT_A_WIDTH+LEN_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [VW-1:0]        vld_q, vld_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [AXW-1:0]       dp_ax_d;
    logic [AYW-1:0]       dp_ay_d;
    logic                 busy_d;
    logic                 in_ready_d;
    logic                 out_valid_d;
    logic                 xfer_c;

    // Next-state, counter, valid pipe and accumulator; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dp_ax_d     = '0;
        dp_ay_d     = '0;
        xfer_c      = in_valid && in_ready && !abort;
        vld_d       = {vld_q[VW-2:0], xfer_c};

        // The tap lines up with the datapath result of the chunk injected DP_LATENCY+1 ago.
        if (vld_q[VW-1]) begin
            acc_d = acc_q + ACC_WIDTH'(dp_result);
        end

        if (xfer_c) begin
            dp_ax_d = in_ax;
            dp_ay_d = in_ay;
            cnt_d   = cnt_q - LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = '0;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer_c && (cnt_q == LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only the tap left means the final add happens on this edge.
                if (vld_q[VW-2:0] == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            vld_d   = '0;
            acc_d   = '0;
            dp_ax_d = '0;
            dp_ay_d = '0;
        end

        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            vld_q     <= '0;
            acc_q     <= '0;
            dp_ax     <= '0;
            dp_ay     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            acc_q     <= acc_d;
            dp_ax     <= dp_ax_d;
            dp_ay     <= dp_ay_d;
            busy      <= busy_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    assign out_result = acc_q;

endmodule

// File: tb/tb_dsp_systolic_dot_ctrl.sv
// Bench for dsp_systolic_dot_ctrl: job-level reference model plus a datapath stub,
// checked every cycle, with literal expectations for the directed jobs.
module tb_dsp_systolic_dot_ctrl;

    localparam int NUM = 10;
    localparam int W   = 27;
    localparam int D   = 3;
    localparam int VW  = NUM * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    len;
    logic          abort;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_ax, in_ay;
    logic [VW-1:0] dp_ax, dp_ay;
    logic [63:0]   dp_result;
    logic          out_valid;
    logic          out_ready;
    logic [71:0]   out_result;

    dsp_systolic_dot_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_ax(in_ax), .in_ay(in_ay),
        .dp_ax(dp_ax), .dp_ay(dp_ay), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Datapath stub: lane dot product, visible D cycles after sampling.
    logic [63:0] pipe [D];
    function automatic logic [63:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [63:0] s = '0;
        for (int i = 0; i < NUM; i++) s += 64'(a[i*W +: W]) * 64'(b[i*W +: W]);
        return s;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= dot(dp_ax, dp_ay);
            for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign dp_result = pipe[D-1];

    // Job-level model: a job is running (taking chunks) or finished (result pending).
    bit            m_run, m_done;
    int            m_left, cyc, done_at, xfer_cyc;
    logic [71:0]   m_sum;
    logic [VW-1:0] m_dpa, m_dpb;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_left = 0; m_sum = '0;
            m_dpa = '0; m_dpb = '0; cyc = 0; done_at = 0; xfer_cyc = 0;
        end else begin
            m_dpa = '0;
            m_dpb = '0;
            if (abort) begin
                m_run = 0; m_done = 0; m_sum = '0;
            end else if (!m_run && !m_done && start) begin
                m_sum = '0;
                if (len == 8'd0) begin
                    m_done = 1; done_at = cyc + 1;
                end else begin
                    m_run = 1; m_left = int'(len);
                end
            end else if (m_run && in_valid) begin
                for (int i = 0; i < NUM; i++) m_sum += 72'(in_ax[i*W +: W]) * 72'(in_ay[i*W +: W]);
                m_dpa = in_ax;
                m_dpb = in_ay;
                xfer_cyc = cyc;
                m_left--;
                if (m_left == 0) begin
                    m_run = 0; m_done = 1; done_at = cyc + 2 + D;
                end
            end else if (m_done && cyc >= done_at && out_ready) begin
                m_done = 0;
            end
            cyc++;
        end
    end

    // Per-cycle compare against the model.
    int rdy_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_result", out_result, 0);
            chk("rst_dp_ax", dp_ax, 0);
            chk("rst_dp_ay", dp_ay, 0);
        end else begin
            chk("busy", busy, m_run || m_done);
            chk("in_ready", in_ready, m_run);
            chk("out_valid", out_valid, m_done && cyc >= done_at);
            chk("dp_ax", dp_ax, m_dpa);
            chk("dp_ay", dp_ay, m_dpb);
            if (m_done && cyc >= done_at) chk("out_result", out_result, m_sum);
            if (in_ready) rdy_cnt++;
        end
    end

    function automatic logic [VW-1:0] fill(input logic [W-1:0] v);
        return {NUM{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int l);
        start = 1'b1;
        len   = 8'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send_chunk(input logic [VW-1:0] a, input logic [VW-1:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_ax    = a;
        in_ay    = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    int ov_cyc;
    task automatic wait_result(input int hold, output logic [71:0] r);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        ov_cyc = cyc;
        repeat (hold) tick();
        r = out_result;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0]   r;
        logic [71:0]   exp;
        logic [VW-1:0] a, b;
        rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_ax = '0; in_ay = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // in_valid ignored while idle
        in_valid = 1'b1; in_ax = fill(27'd9); in_ay = fill(27'd9);
        repeat (3) tick();
        in_valid = 1'b0;

        // len=1, ax=1, ay=2; a stray start during drain is ignored
        start_job(1);
        send_chunk(fill(27'd1), fill(27'd2), 0);
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        wait_result(0, r);
        chk("t1_result", r, 72'd20);
        chk("t1_latency", 512'(ov_cyc - xfer_cyc), 5);

        // len=3 back-to-back at max operand
        rdy_cnt = 0;
        start_job(3);
        for (int c = 0; c < 3; c++) send_chunk(fill(27'h7FFFFFF), fill(27'h7FFFFFF), 0);
        wait_result(0, r);
        chk("t2_result", r, 72'd540431947231395870);
        chk("t2_ready_cycles", rdy_cnt, 3);

        // len=0 completes immediately; result held while out_ready is low
        start_job(0);
        chk("t3_done_next", out_valid, 1);
        wait_result(4, r);
        chk("t3_result", r, 0);

        // len=16 with random gaps and operands
        exp = '0;
        start_job(16);
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NUM; i++) begin
                a[i*W +: W] = W'($urandom);
                b[i*W +: W] = W'($urandom);
                exp += 72'(a[i*W +: W]) * 72'(b[i*W +: W]);
            end
            send_chunk(a, b, int'($urandom_range(0, 3)));
        end
        wait_result(2, r);
        chk("t4_result", r, exp);

        // abort during drain, then a clean job
        start_job(1);
        send_chunk(fill(27'd5), fill(27'd7), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_idle", busy, 0);
        start_job(1);
        send_chunk(fill(27'd1), fill(27'd1), 0);
        wait_result(0, r);
        chk("t5_result", r, 72'd10);

        // reset pulse mid-run, then a fresh job
        start_job(4);
        send_chunk(fill(27'd4), fill(27'd4), 0);
        send_chunk(fill(27'd4), fill(27'd4), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_dp_ax", dp_ax, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        start_job(1);
        send_chunk(fill(27'd1), fill(27'd3), 0);
        wait_result(0, r);
        chk("t6_result", r, 72'd30);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_systolic_dot_ctrl.md
DSP_SYSTOLIC_DOT_CTRL -- requirements
Module: dsp_systolic_dot_ctrl

Interface
REQ-001 SHALL have parameter NUM, default 10: number of multiplier stages in the systolic chain, i.e. operand pairs per chunk.
REQ-002 SHALL have parameter AX_WIDTH, default 27: unsigned X operand width.
REQ-003 SHALL have parameter AY_WIDTH, default 27: unsigned Y operand width.
REQ-004 SHALL have parameter RESULT_A_WIDTH, default 64: width of the datapath chain result.
REQ-005 SHALL have parameter DP_LATENCY, default 3: cycles from the datapath sampling dp_ax/dp_ay to the matching dp_result.
REQ-006 SHALL have parameter LEN_WIDTH, default 8: width of the job length in chunks.
REQ-007 SHALL have parameter ACC_WIDTH, default 72: accumulator width; SHALL be at least RESULT_A_WIDTH+LEN_WIDTH.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit: job launch pulse.
REQ-011 SHALL have port len, input, LEN_WIDTH bits: chunk count, sampled with start.
REQ-012 SHALL have port abort, input, 1 bit: synchronous job cancel.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have ports in_valid (input, 1) and in_ready (output, 1): chunk handshake.
REQ-015 SHALL have ports in_ax (input, NUM*AX_WIDTH) and in_ay (input, NUM*AY_WIDTH): chunk operands, lane i at bits [i*W +: W].
REQ-016 SHALL have ports dp_ax (output, NUM*AX_WIDTH) and dp_ay (output, NUM*AY_WIDTH): registered operands to the systolic datapath.
REQ-017 SHALL have port dp_result, input, RESULT_A_WIDTH bits: chain result returned by the datapath.
REQ-018 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_result (output, ACC_WIDTH): job result handshake.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-020 SHALL in IDLE, on start, latch len into the remaining-chunk counter; len>0 -> RUN, len==0 -> DONE with out_result=0; the accumulator is cleared on every accepted start.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL drive in_ready=1 only in RUN; a chunk transfers when in_valid&&in_ready; each transfer decrements the counter; the transfer of the last chunk -> DRAIN.
REQ-023 SHALL register dp_ax/dp_ay with the accepted chunk in cycle t+1 when a chunk transfers in cycle t, and with all-zero otherwise, so that idle cycles inject zero products.
REQ-024 SHALL track in-flight chunks with a DP_LATENCY+1 deep valid shift register; when its tap is set, zero-extended dp_result SHALL be added to the accumulator at the end of cycle t+1+DP_LATENCY.
REQ-025 SHALL accept back-to-back chunks at one per cycle, with no bubble required.
REQ-026 SHALL leave DRAIN for DONE once the valid shift register is empty and the final accumulation is done; for a len=1 job accepted in cycle t, out_valid SHALL rise in cycle t+2+DP_LATENCY.
REQ-027 SHALL in DONE hold out_valid=1 and out_result stable until out_ready; on out_valid&&out_ready -> IDLE with out_valid=0 next cycle.
REQ-028 SHALL apply arithmetic modulo 2^ACC_WIDTH; by REQ-007 no overflow is reachable at legal parameters.
REQ-029 SHALL, on abort in any state, go to IDLE next cycle: valid shift register cleared, dp operands zeroed, out_valid=0, accumulator cleared; abort SHALL take priority over start and over any simultaneous handshake, and no transfer is counted in that cycle.
REQ-030 SHALL ignore in_valid in IDLE, DRAIN and DONE.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force: state IDLE, busy=0, in_ready=0, out_valid=0, out_result=0, dp_ax=0, dp_ay=0, accumulator=0, counter=0, valid shift register=0.
REQ-032 SHALL release from reset on the first rising clk edge after rst_n goes high, with no spurious accumulation of dp_result.

Verification
REQ-033 SHALL cover: len=1, all ax=1, ay=2, reference datapath model -> out_result=20, with out_valid exactly 5 cycles after the transfer cycle at DP_LATENCY=3.
REQ-034 SHALL cover: len=3 back-to-back chunks, all lanes ax=ay=2^27-1 -> out_result=30*(2^27-1)^2, with in_ready high for exactly 3 transfer cycles.
REQ-035 SHALL cover: start with len=0 -> DONE next cycle, out_result=0; out_ready held low for 4 cycles -> out_valid and out_result stable throughout.
REQ-036 SHALL cover: random in_valid gaps, len=16, random operands -> result equals the sum of all lane products, and dp_ax=0 in every gap cycle.
REQ-037 SHALL cover: abort asserted during DRAIN, then a new len=1 job with ax=ay=1 -> out_result=10, with no residue from the aborted job.
REQ-038 SHALL cover: rst_n pulsed low mid-RUN -> all outputs at reset values immediately, and start is honoured after release.
